// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// MEM-stage load/store unit. Decodes RISC-V funct3 for RV32/RV64 load and
// store widths, drives a request/grant/response data-memory bus, aligns store
// data and byte strobes, and extracts plus sign/zero-extends load data.
// Word-crossing misaligned accesses are split into two aligned bus beats.
//
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN
//   defined   : misaligned accesses are performed (split when they cross a
//               bus word); only an illegal funct3 faults.
//   undefined : any misaligned access faults without touching the bus, and
//               the second-beat logic is not built.
//
// Parameters
//   XLEN   : datapath / bus width, 32 or 64
//   ADDR_W : byte address width
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : pipeline request handshake (ready only in IDLE)
//   req_we, funct_3        : store flag and access width/sign code
//   req_addr, req_wdata    : byte address, LSB-justified store data
//   busy                   : pipeline stall, equals !req_ready
//   resp_valid             : one-cycle completion pulse
//   resp_rdata, resp_fault : extended load data, fault flag (with resp_valid)
//   mem_req/mem_gnt        : bus request handshake
//   mem_we, mem_addr       : bus write flag, word-aligned address
//   mem_wstrb, mem_wdata   : byte enables, lane-aligned write data
//   mem_rvalid, mem_rdata  : read data / write ack, one per granted beat
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          funct_3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                busy,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic                resp_fault,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_wstrb,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned OFFW  = $clog2(BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ0,
      S_WAIT0,
      S_REQ1,
      S_WAIT1,
      S_RESP
   } state_e;

   state_e              state_q, state_d;

   logic                we_q;
   logic                sext_q;
   logic                fault_q;
   logic [3:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [XLEN-1:0]     wdata_q;
   logic [XLEN-1:0]     beat0_q;
   logic [XLEN-1:0]     beat1_w;

   // request decode
   logic                accept;
   logic                dec_legal;
   logic                dec_sext;
   logic [3:0]          dec_size;
   logic                dec_fault;
   logic [OFFW-1:0]     req_off;

   // datapath
   logic [OFFW-1:0]     off;
   logic [ADDR_W-1:0]   word_addr;
   logic [7:0]          mask8;
   logic [BYTES-1:0]    strb0;
   logic [XLEN-1:0]     wdata0;
   logic [XLEN-1:0]     raw;
   logic                sbit;
   logic [XLEN-1:0]     load_ext;

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic                cross_q;
   logic                dec_cross;
   logic [XLEN-1:0]     beat1_q;
   logic [BYTES-1:0]    strb1;
   logic [XLEN-1:0]     wdata1;
`else
   logic                dec_mis;
`endif

   assign accept  = req_valid && (state_q == S_IDLE);
   assign req_off = req_addr[OFFW-1:0];

   // ---------------------------------------------------------------------------
   // funct3 decode: legality, size in bytes, sign extension
   // ---------------------------------------------------------------------------
   always_comb begin
      dec_legal = 1'b0;
      dec_size  = 4'd0;
      dec_sext  = 1'b0;
      if (!req_we) begin
         case (funct_3)
            3'b000: begin dec_legal = 1'b1; dec_size = 4'd1; dec_sext = 1'b1; end
            3'b001: begin dec_legal = 1'b1; dec_size = 4'd2; dec_sext = 1'b1; end
            3'b010: begin dec_legal = 1'b1; dec_size = 4'd4; dec_sext = 1'b1; end
            3'b100: begin dec_legal = 1'b1; dec_size = 4'd1; end
            3'b101: begin dec_legal = 1'b1; dec_size = 4'd2; end
            3'b011: begin
               if (XLEN == 64) begin
                  dec_legal = 1'b1;
                  dec_size  = 4'd8;
                  dec_sext  = 1'b1;
               end
            end
            3'b110: begin
               if (XLEN == 64) begin
                  dec_legal = 1'b1;
                  dec_size  = 4'd4;
               end
            end
            default: ;
         endcase
      end else begin
         case (funct_3)
            3'b000: begin dec_legal = 1'b1; dec_size = 4'd1; end
            3'b001: begin dec_legal = 1'b1; dec_size = 4'd2; end
            3'b010: begin dec_legal = 1'b1; dec_size = 4'd4; end
            3'b011: begin
               if (XLEN == 64) begin
                  dec_legal = 1'b1;
                  dec_size  = 4'd8;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LSU_MISALIGNED_SPLIT_EN
   assign dec_cross = (5'(req_off) + 5'(dec_size)) > 5'(BYTES);
   assign dec_fault = !dec_legal;
`else
   // sizes are powers of two, so off % size reduces to a mask test
   assign dec_mis   = |(4'(req_off) & (dec_size - 4'd1));
   assign dec_fault = !dec_legal || dec_mis;
`endif

   // ---------------------------------------------------------------------------
   // State and request registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         fault_q <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         beat0_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
         cross_q <= 1'b0;
         beat1_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            sext_q  <= dec_sext;
            fault_q <= dec_fault;
            size_q  <= dec_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cross_q <= dec_cross;
`endif
         end
         if ((state_q == S_WAIT0) && mem_rvalid) begin
            beat0_q <= mem_rdata;
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         if ((state_q == S_WAIT1) && mem_rvalid) begin
            beat1_q <= mem_rdata;
         end
`endif
      end
   end

`ifdef LSU_MISALIGNED_SPLIT_EN
   assign beat1_w = beat1_q;
`else
   assign beat1_w = '0;
`endif

   // ---------------------------------------------------------------------------
   // Lane alignment and load extraction
   // ---------------------------------------------------------------------------
   always_comb begin
      off       = addr_q[OFFW-1:0];
      word_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
      case (size_q)
         4'd1:    mask8 = 8'h01;
         4'd2:    mask8 = 8'h03;
         4'd4:    mask8 = 8'h0F;
         4'd8:    mask8 = 8'hFF;
         default: mask8 = 8'h00;
      endcase
      // bits shifted past the top of the word belong to the second beat
      strb0  = BYTES'({8'h00, mask8} << off);
      wdata0 = wdata_q << {off, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
      strb1  = BYTES'({8'h00, mask8} >> (BYTES - 32'(off)));
      wdata1 = wdata_q >> (8 * (BYTES - 32'(off)));
`endif

      // {beat1,beat0} forms a contiguous little-endian window starting at the word
      raw = XLEN'({beat1_w, beat0_q} >> {off, 3'b000});
      case (size_q)
         4'd1:    sbit = raw[7];
         4'd2:    sbit = raw[15];
         4'd4:    sbit = raw[31];
         default: sbit = raw[XLEN-1];
      endcase
      load_ext = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         if (i < 32'({size_q, 3'b000})) begin
            load_ext[i] = raw[i];
         end else begin
            load_ext[i] = sext_q & sbit;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      resp_rdata = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wstrb  = '0;
      mem_wdata  = '0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = dec_fault ? S_RESP : S_REQ0;
            end
         end
         S_REQ0: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = word_addr;
            mem_wstrb = we_q ? strb0 : '0;
            mem_wdata = wdata0;
            if (mem_gnt) begin
               state_d = S_WAIT0;
            end
         end
         S_WAIT0: begin
            if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
               state_d = cross_q ? S_REQ1 : S_RESP;
`else
               state_d = S_RESP;
`endif
            end
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         S_REQ1: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = word_addr + ADDR_W'(BYTES);
            mem_wstrb = we_q ? strb1 : '0;
            mem_wdata = wdata1;
            if (mem_gnt) begin
               state_d = S_WAIT1;
            end
         end
         S_WAIT1: begin
            if (mem_rvalid) begin
               state_d = S_RESP;
            end
         end
`endif
         S_RESP: begin
            resp_valid = 1'b1;
            resp_fault = fault_q;
            resp_rdata = (!we_q && !fault_q) ? load_ext : '0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = !req_ready;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed self-checking bench for lsu_mem_ctrl at XLEN=32, ADDR_W=32.
// Inputs change and outputs are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  funct_3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_req;
   logic        mem_gnt;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int tests;
   int fails;

   lsu_mem_ctrl #(
      .XLEN   (32),
      .ADDR_W (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .funct_3    (funct_3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what,
                      input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // One access on a zero-wait bus. beats=0 means a fault is expected at
   // cycle 1; otherwise each beat is checked while mem_req is high and the
   // response is checked after the last beat.
   task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int beats,
                       input logic [31:0] a0, input logic [3:0] s0,
                       input logic [31:0] w0, input logic [31:0] rd0,
                       input logic [31:0] a1, input logic [3:0] s1,
                       input logic [31:0] w1, input logic [31:0] rd1,
                       input logic [31:0] exp_rd);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      funct_3   = f3;
      req_addr  = addr;
      req_wdata = wd;
      mem_gnt   = 1'b1;
      #1 chk(tag, "ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (beats == 0) begin
         chk(tag, "resp_valid", resp_valid, 1);
         chk(tag, "resp_fault", resp_fault, 1);
         chk(tag, "resp_rdata", resp_rdata, 0);
         chk(tag, "mem_req", mem_req, 0);
      end else begin
         for (int b = 0; b < beats; b++) begin
            chk(tag, "mem_req", mem_req, 1);
            chk(tag, "busy", busy, 1);
            chk(tag, "mem_we", mem_we, we);
            chk(tag, "mem_addr", mem_addr, (b == 0) ? a0 : a1);
            chk(tag, "mem_wstrb", mem_wstrb, (b == 0) ? s0 : s1);
            if (we) chk(tag, "mem_wdata", mem_wdata, (b == 0) ? w0 : w1);
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = (b == 0) ? rd0 : rd1;
            #1 chk(tag, "wait_req", mem_req, 0);
            @(negedge clk);
            mem_rvalid = 1'b0;
            #1;
         end
         chk(tag, "resp_valid", resp_valid, 1);
         chk(tag, "resp_fault", resp_fault, 0);
         chk(tag, "resp_rdata", resp_rdata, exp_rd);
      end
      @(negedge clk);
      #1;
      chk(tag, "pulse_end", resp_valid, 0);
      chk(tag, "idle_ready", req_ready, 1);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      funct_3    = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset", "req_ready", req_ready, 1);
      chk("reset", "busy", busy, 0);
      chk("reset", "resp_valid", resp_valid, 0);
      chk("reset", "resp_fault", resp_fault, 0);
      chk("reset", "resp_rdata", resp_rdata, 0);
      chk("reset", "mem_req", mem_req, 0);
      chk("reset", "mem_we", mem_we, 0);
      chk("reset", "mem_addr", mem_addr, 0);
      chk("reset", "mem_wstrb", mem_wstrb, 0);
      chk("reset", "mem_wdata", mem_wdata, 0);
      rst = 1'b0;

      // aligned and non-crossing loads
      xact("lw",  1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
      xact("lb",  1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'h80FFFFFF, 32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80);
      xact("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'h80FFFFFF, 32'h0, 4'h0, 32'h0, 32'h0, 32'h00000080);
      xact("lh",  1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'h80011234, 32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF8001);
      xact("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'h80011234, 32'h0, 4'h0, 32'h0, 32'h0, 32'h00008001);

      // aligned stores
      xact("sh",  1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1, 32'h100, 4'b1100,
           32'hABCD0000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
      xact("sb",  1'b1, 3'b000, 32'h101, 32'h000000AA, 1, 32'h100, 4'b0010,
           32'h0000AA00, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
      xact("sw",  1'b1, 3'b010, 32'h104, 32'h01234567, 1, 32'h104, 4'b1111,
           32'h01234567, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);

`ifdef LSU_MISALIGNED_SPLIT_EN
      // split and misaligned-but-contained accesses
      xact("sw_split", 1'b1, 3'b010, 32'h103, 32'h11223344, 2,
           32'h100, 4'b1000, 32'h44000000, 32'h0,
           32'h104, 4'b0111, 32'h00112233, 32'h0, 32'h0);
      xact("lw_split", 1'b0, 3'b010, 32'h102, 32'h0, 2,
           32'h100, 4'h0, 32'h0, 32'h55667788,
           32'h104, 4'h0, 32'h0, 32'h11223344, 32'h33445566);
      xact("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 2,
           32'hFFFFFFFC, 4'b1100, 32'hC3D40000, 32'h0,
           32'h00000000, 4'b0011, 32'h0000A1B2, 32'h0, 32'h0);
      xact("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h100, 4'h0, 32'h0,
           32'h00CDAB00, 32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFCDAB);
`else
      // misaligned accesses fault without a bus request
      xact("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
      xact("sh_mis", 1'b1, 3'b001, 32'h101, 32'h1234, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
`endif

      // illegal funct3 codes fault in both builds
      xact("ld_111", 1'b0, 3'b111, 32'h100, 32'h0, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
      xact("ld_rv64", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);
      xact("st_100", 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0);

      // grant stall with stable bus signals, then reset during WAIT0
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      funct_3   = 3'b010;
      req_addr  = 32'h200;
      req_wdata = 32'hCAFEF00D;
      mem_gnt   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         chk("stall", "mem_req", mem_req, 1);
         chk("stall", "mem_we", mem_we, 1);
         chk("stall", "mem_addr", mem_addr, 32'h200);
         chk("stall", "mem_wstrb", mem_wstrb, 4'hF);
         chk("stall", "mem_wdata", mem_wdata, 32'hCAFEF00D);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      chk("wait0", "mem_req", mem_req, 0);
      chk("wait0", "busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort", "req_ready", req_ready, 1);
      chk("abort", "busy", busy, 0);
      chk("abort", "resp_valid", resp_valid, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("stray", "resp_valid", resp_valid, 0);
      chk("stray", "mem_req", mem_req, 0);
      chk("stray", "req_ready", req_ready, 1);

      // normal operation after the abort
      xact("lw_post", 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h300, 4'h0, 32'h0,
           32'h0BADF00D, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
